dmem_resp_gen: RTL and testbench

- Responder-side companion to the command-valid clipper on the ORAM backend command interface.
- Watches each backend command actually accepted (valid & ready) and tracks it to completion:
  - reads: consumes the multi-beat data block the backend returns;
  - writes: waits for the backend write-done pulse.
- Emits a one-cycle io_dmem_resp_valid pulse with the requested word. That pulse releases the clipper for the next command.
- Sits between the ORAM backend data/ack outputs and the core's dmem response port.

---
 rtl/dmem_resp_gen.sv | 95 +++++++++
 tb/tb_dmem_resp_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp_gen.sv
// Tracks each accepted ORAM backend command to completion and emits a one-cycle dmem response.
// Reads take the requested beat out of the returned block; writes wait for WriteDone.
module dmem_resp_gen #(
    parameter int                    BECMDWidth    = 2,
    parameter logic [BECMDWidth-1:0] BECMD_Read    = 1,
    parameter int                    FEDWidth      = 64,
    parameter int                    BeatsPerBlock = 8,
    parameter int                    OffsetWidth   = 3
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   InCmdValid,
    input  logic                   InCmdReady,
    input  logic [BECMDWidth-1:0]  InCmd,
    input  logic [OffsetWidth-1:0] InWordOffset,
    input  logic                   DataOutValid,
    output logic                   DataOutReady,
    input  logic [FEDWidth-1:0]    DataOut,
    input  logic                   WriteDone,
    output logic                   io_dmem_resp_valid,
    output logic [FEDWidth-1:0]    io_dmem_resp_data,
    output logic                   io_dmem_resp_is_write,
    output logic                   Busy,
    output logic                   Error
);
    localparam logic [OffsetWidth-1:0] LastBeat = OffsetWidth'(BeatsPerBlock - 1);

    typedef enum logic [1:0] {IDLE, WAIT_READ, WAIT_WRITE, RESP} state_t;

    state_t                 state, state_nxt;
    logic [OffsetWidth-1:0] beat_cnt;
    logic [OffsetWidth-1:0] word_off;
    logic [FEDWidth-1:0]    word;
    logic                   accept, beat, last_beat, cap_hit, err_now;

    assign accept    = InCmdValid & InCmdReady;
    assign beat      = DataOutValid & DataOutReady;
    assign last_beat = beat && (beat_cnt == LastBeat);
    assign cap_hit   = beat && (beat_cnt == word_off);

    assign DataOutReady       = (state == WAIT_READ);
    assign io_dmem_resp_valid = (state == RESP);
    assign Busy               = (state != IDLE);

    assign err_now = (accept && state != IDLE)
                   | (DataOutValid && state != WAIT_READ)
                   | (WriteDone && state != WAIT_WRITE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (accept) state_nxt = (InCmd == BECMD_Read) ? WAIT_READ : WAIT_WRITE;
            WAIT_READ:  if (last_beat) state_nxt = RESP;
            WAIT_WRITE: if (WriteDone) state_nxt = RESP;
            RESP:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Response data is registered on the way into RESP so it holds while the next command runs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            beat_cnt              <= '0;
            word_off              <= '0;
            word                  <= '0;
            io_dmem_resp_data     <= '0;
            io_dmem_resp_is_write <= 1'b0;
            Error                 <= 1'b0;
        end else begin
            Error <= Error | err_now;
            if (state == IDLE && accept) begin
                word_off <= InWordOffset;
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + OffsetWidth'(1);
                if (cap_hit) word <= DataOut;
            end
            if (last_beat) begin
                io_dmem_resp_data     <= cap_hit ? DataOut : word;
                io_dmem_resp_is_write <= 1'b0;
            end
            if (state == WAIT_WRITE && WriteDone) begin
                word                  <= '0;
                io_dmem_resp_data     <= '0;
                io_dmem_resp_is_write <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_resp_gen.sv
// Directed scenarios plus a random soak, each cycle checked against a transaction-level model.
module tb_dmem_resp_gen;
    localparam int W = 64;
    localparam int NB = 8;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         InCmdValid = 1'b0, InCmdReady = 1'b0;
    logic [1:0]   InCmd = '0;
    logic [2:0]   InWordOffset = '0;
    logic         DataOutValid = 1'b0;
    logic         DataOutReady;
    logic [W-1:0] DataOut = '0;
    logic         WriteDone = 1'b0;
    logic         io_dmem_resp_valid;
    logic [W-1:0] io_dmem_resp_data;
    logic         io_dmem_resp_is_write;
    logic         Busy, Error;

    dmem_resp_gen dut (
        .Clock(Clock), .Reset(Reset),
        .InCmdValid(InCmdValid), .InCmdReady(InCmdReady), .InCmd(InCmd),
        .InWordOffset(InWordOffset),
        .DataOutValid(DataOutValid), .DataOutReady(DataOutReady), .DataOut(DataOut),
        .WriteDone(WriteDone),
        .io_dmem_resp_valid(io_dmem_resp_valid), .io_dmem_resp_data(io_dmem_resp_data),
        .io_dmem_resp_is_write(io_dmem_resp_is_write),
        .Busy(Busy), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    // Model: one outstanding transaction, its received block, and the pending response.
    bit           m_out, m_rd, m_resp, m_wr, m_err;
    int           m_off, m_beats;
    logic [W-1:0] m_blk [NB];
    logic [W-1:0] m_data;

    int           pulses;
    logic [W-1:0] pulse_data;
    logic         pulse_wr;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_rd = 0; m_resp = 0; m_wr = 0; m_err = 0;
        m_off = 0; m_beats = 0; m_data = '0;
    endtask

    task automatic model_update();
        bit acc;
        if (!Reset) begin
            model_reset();
            return;
        end
        acc = InCmdValid & InCmdReady;
        if (acc && (m_out || m_resp)) m_err = 1;
        if (DataOutValid && !(m_out && m_rd)) m_err = 1;
        if (WriteDone && !(m_out && !m_rd)) m_err = 1;
        if (m_resp) begin
            m_resp = 0;
        end else if (m_out && m_rd) begin
            if (DataOutValid) begin
                m_blk[m_beats] = DataOut;
                m_beats++;
                if (m_beats == NB) begin
                    m_out = 0; m_resp = 1; m_wr = 0; m_data = m_blk[m_off];
                end
            end
        end else if (m_out) begin
            if (WriteDone) begin
                m_out = 0; m_resp = 1; m_wr = 1; m_data = '0;
            end
        end else if (acc) begin
            m_out = 1; m_rd = (InCmd == 2'd1); m_off = int'(InWordOffset); m_beats = 0;
        end
    endtask

    // Compare just before the edge, then advance the model with the inputs that edge will see.
    task automatic step();
        @(negedge Clock);
        check("resp_valid", W'(io_dmem_resp_valid), W'(m_resp));
        check("busy", W'(Busy), W'(m_out || m_resp));
        check("data_ready", W'(DataOutReady), W'(m_out && m_rd));
        check("error", W'(Error), W'(m_err));
        check("resp_data", io_dmem_resp_data, m_data);
        check("resp_is_write", W'(io_dmem_resp_is_write), W'(m_wr));
        if (io_dmem_resp_valid) begin
            pulses++;
            pulse_data = io_dmem_resp_data;
            pulse_wr = io_dmem_resp_is_write;
        end
        model_update();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        InCmdValid = 0; InCmdReady = 0; DataOutValid = 0; WriteDone = 0;
    endtask

    task automatic cmd(input logic [1:0] c, input logic [2:0] off);
        InCmdValid = 1; InCmdReady = 1; InCmd = c; InWordOffset = off;
        step();
        InCmdValid = 0; InCmdReady = 0;
    endtask

    task automatic send_beats(input logic [W-1:0] base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            DataOutValid = 1; DataOut = base + W'(i);
            step();
            DataOutValid = 0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic do_reset();
        idle_in();
        Reset = 0;
        #1;
        check("rst_valid", W'(io_dmem_resp_valid), '0);
        check("rst_data", io_dmem_resp_data, '0);
        check("rst_is_write", W'(io_dmem_resp_is_write), '0);
        check("rst_busy", W'(Busy), '0);
        check("rst_ready", W'(DataOutReady), '0);
        check("rst_error", W'(Error), '0);
        model_reset();
        step(); step();
        Reset = 1;
        step();
        pulses = 0;
    endtask

    initial begin
        logic [W-1:0] base;
        model_reset();
        pulses = 0; pulse_data = '0; pulse_wr = 0;

        // Read at offset 3, back-to-back beats.
        do_reset();
        cmd(2'd1, 3'd3);
        send_beats(64'h100, 8, 0);
        step(); step();
        check("s1_pulses", W'(pulses), W'(1));
        check("s1_data", pulse_data, 64'h103);
        check("s1_is_write", W'(pulse_wr), '0);
        check("s1_busy_after", W'(Busy), '0);

        // Read at offset 7 with gaps: the captured beat is the final one.
        base = {$urandom, $urandom};
        cmd(2'd1, 3'd7);
        send_beats(base, 7, 2);
        check("s2_no_early", W'(pulses), W'(1));
        send_beats(base + 64'd7, 1, 0);
        step(); step();
        check("s2_pulses", W'(pulses), W'(2));
        check("s2_data", pulse_data, base + 64'd7);

        // Write with WriteDone 20 cycles after accept.
        cmd(2'd2, 3'd5);
        repeat (19) step();
        WriteDone = 1; step(); WriteDone = 0;
        step(); step();
        check("s3_pulses", W'(pulses), W'(3));
        check("s3_data", pulse_data, '0);
        check("s3_is_write", W'(pulse_wr), W'(1));
        check("s3_no_error", W'(Error), '0);

        // Accepts during WAIT_READ and during RESP are ignored and flag Error.
        do_reset();
        cmd(2'd1, 3'd2);
        send_beats(64'hA00, 3, 0);
        cmd(2'd0, 3'd5);
        send_beats(64'hA03, 5, 0);
        InCmdValid = 1; InCmdReady = 1; InCmd = 2'd1;
        step();
        idle_in();
        repeat (10) step();
        check("s4_error", W'(Error), W'(1));
        check("s4_pulses", W'(pulses), W'(1));
        check("s4_data", pulse_data, 64'hA02);
        check("s4_busy", W'(Busy), '0);

        // Asynchronous reset after beat 4, then a clean read at offset 0.
        do_reset();
        cmd(2'd1, 3'd1);
        send_beats(64'hB00, 5, 0);
        do_reset();
        base = {$urandom, $urandom};
        cmd(2'd1, 3'd0);
        send_beats(base, 8, 1);
        step(); step();
        check("s5_pulses", W'(pulses), W'(1));
        check("s5_data", pulse_data, base);

        // Stray beat in IDLE, stray WriteDone during a read.
        do_reset();
        DataOutValid = 1; DataOut = 64'hDEAD; step(); DataOutValid = 0;
        check("s6_err_idle", W'(Error), W'(1));
        cmd(2'd1, 3'd4);
        WriteDone = 1; step(); WriteDone = 0;
        send_beats(64'hC00, 8, 0);
        step(); step();
        check("s6_pulses", W'(pulses), W'(1));
        check("s6_data", pulse_data, 64'hC04);

        // Accept in IDLE together with a stray WriteDone: command taken, Error set.
        do_reset();
        InCmdValid = 1; InCmdReady = 1; InCmd = 2'd3; InWordOffset = 3'd0; WriteDone = 1;
        step();
        idle_in();
        repeat (3) step();
        WriteDone = 1; step(); WriteDone = 0;
        step(); step();
        check("s7_pulses", W'(pulses), W'(1));
        check("s7_is_write", W'(pulse_wr), W'(1));

        // Random soak, reset periodically so Error is exercised from clear.
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                InCmdValid   = ($urandom_range(0, 5) == 0);
                InCmdReady   = ($urandom_range(0, 1) == 0);
                InCmd        = 2'($urandom_range(0, 3));
                InWordOffset = 3'($urandom_range(0, 7));
                DataOutValid = ($urandom_range(0, 2) == 0);
                DataOut      = {$urandom, $urandom};
                WriteDone    = ($urandom_range(0, 15) == 0);
                step();
            end
            idle_in();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
